dmem_responder: RTL and testbench

- Data-memory responder: the memory end of the core's load/store interface.
- Accepts one load or store request per handshake and applies RV32I byte, halfword and word semantics (funct3-encoded size and sign).
- Returns a registered response one cycle after acceptance, with backpressure support and a misalignment/illegal-size error flag.
- Sits between the processor datapath (ALUResult as address, WriteData as store data) and local word storage. Replaces the bare block-RAM instance when sub-word access is required.

---
 rtl/dmem_responder.sv | 160 ++++++++++++++++
 tb/tb_dmem_responder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder
//   Memory end of the core's load/store interface. Accepts one load or store
//   per request handshake, applies RV32I byte/halfword/word semantics selected
//   by funct3, and returns a registered response one cycle after acceptance.
//   The response holds while the consumer applies backpressure. Misaligned
//   accesses and illegal funct3 codes are flagged with rsp_err and leave the
//   storage untouched.
//
// Ports
//   clk         rising-edge clock for all logic
//   reset       synchronous, active-low reset
//   req_valid   request present
//   req_ready   responder can accept a request this cycle
//   req_we      1 = store, 0 = load
//   req_funct3  000 B, 001 H, 010 W, 100 BU, 101 HU
//   req_addr    byte address (word index = [ADDR_W-1:2], lane = [1:0])
//   req_wdata   right-aligned store data
//   rsp_valid   response present
//   rsp_ready   consumer accepts the response
//   rsp_rdata   extended load result; 0 for stores and errors
//   rsp_err     request was misaligned or had an illegal funct3
// ----------------------------------------------------------------------------
module dmem_responder #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int DEPTH = 2 ** (ADDR_W - 2);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RESP = 1'b1;

    logic [0:0]        state;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic              req_err;
    logic [3:0]        byte_en;
    logic [DATA_W-1:0] store_lanes;
    logic [DATA_W-1:0] load_word;
    logic [DATA_W-1:0] load_shifted;
    logic [DATA_W-1:0] load_val;

    logic [ADDR_W-3:0] word_idx;
    logic [1:0]        lane;

    assign word_idx  = req_addr[ADDR_W-1:2];
    assign lane      = req_addr[1:0];

    assign rsp_valid = (state == ST_RESP);
    // A new request may enter whenever the output slot is empty or is being
    // drained this same cycle.
    assign req_ready = !rsp_valid || rsp_ready;
    assign accept    = req_valid && req_ready;

    // Legality and alignment of the presented request.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        req_err = 1'b0;
        if (req_we) begin
            if (req_funct3[2] || (req_funct3[1:0] == 2'b11))
                req_err = 1'b1;
        end else begin
            if (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111)
                req_err = 1'b1;
        end
        if (req_funct3[1:0] == 2'b01 && req_addr[0])
            req_err = 1'b1;
        if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)
            req_err = 1'b1;
    end

    // Store byte enables and lane-replicated store data: replicating the
    // right-aligned value across the word lets each enabled lane pick its
    // byte straight from the same bit position.
    always_comb begin
        byte_en     = 4'b0000;
        store_lanes = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                byte_en     = 4'b0001 << lane;
                store_lanes = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                byte_en     = lane[1] ? 4'b1100 : 4'b0011;
                store_lanes = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                byte_en     = 4'b1111;
                store_lanes = req_wdata;
            end
            default: begin
                byte_en     = 4'b0000;
                store_lanes = req_wdata;
            end
        endcase
    end

    // Load path: read the addressed word, shift the selected lane down to
    // bit 0, then extend according to funct3.
    always_comb begin
        load_word    = mem[word_idx];
        load_shifted = load_word >> {lane, 3'b000};
        load_val     = '0;
        case (req_funct3)
            3'b000:  load_val = {{24{load_shifted[7]}},  load_shifted[7:0]};
            3'b001:  load_val = {{16{load_shifted[15]}}, load_shifted[15:0]};
            3'b010:  load_val = load_word;
            3'b100:  load_val = {24'h0, load_shifted[7:0]};
            3'b101:  load_val = {16'h0, load_shifted[15:0]};
            default: load_val = '0;
        endcase
    end

    // Storage. The write is gated by reset so a store presented during reset
    // is dropped.
    // NOTE: the storage array has no reset on purpose; clearing it would
    // force flops instead of RAM and would lose contents across a reset.
    always_ff @(posedge clk) begin
        if (reset && accept && req_we && !req_err) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i])
                    mem[word_idx][8*i +: 8] <= store_lanes[8*i +: 8];
            end
        end
    end

    // Response FSM and registered response payload.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!reset) begin
            state     <= ST_IDLE;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (accept) begin
            state     <= ST_RESP;
            rsp_err   <= req_err;
            rsp_rdata <= (req_err || req_we) ? '0 : load_val;
        end else if (rsp_valid && rsp_ready) begin
            state     <= ST_IDLE;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// ----------------------------------------------------------------------------
// tb_dmem_responder
//   Directed bench for dmem_responder. Inputs change on the falling edge;
//   outputs are sampled #1 after the rising edge or on the falling edge.
// ----------------------------------------------------------------------------
module tb_dmem_responder;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_compared   = 0;
    int n_mismatched = 0;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    dmem_responder #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One request with rsp_ready held high; checks the response that
    // appears right after the accepting edge.
    task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                        input logic [7:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_d, input logic exp_e);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        check({tag, ".req_ready"}, {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check({tag, ".rsp_valid"}, {31'h0, rsp_valid}, 32'h1);
        check({tag, ".rsp_rdata"}, rsp_rdata, exp_d);
        check({tag, ".rsp_err"},   {31'h0, rsp_err},   {31'h0, exp_e});
    endtask

    initial begin
        int valid_run;

        reset      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = F_W;
        req_addr   = 8'h00;
        req_wdata  = 32'h0;
        rsp_ready  = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        check("reset.rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("reset.req_ready", {31'h0, req_ready}, 32'h1);
        check("reset.rsp_rdata", rsp_rdata, 32'h0);
        check("reset.rsp_err",   {31'h0, rsp_err},   32'h0);

        // 1: word store then word load
        xact("sw10",  1'b1, F_W,  8'h10, 32'hDEADBEEF, 32'h00000000, 1'b0);
        xact("lw10a", 1'b0, F_W,  8'h10, 32'h0,        32'hDEADBEEF, 1'b0);

        // 2: sub-word loads with sign/zero extension
        xact("lb13",  1'b0, F_B,  8'h13, 32'h0, 32'hFFFFFFDE, 1'b0);
        xact("lbu13", 1'b0, F_BU, 8'h13, 32'h0, 32'h000000DE, 1'b0);
        xact("lh12",  1'b0, F_H,  8'h12, 32'h0, 32'hFFFFDEAD, 1'b0);
        xact("lhu10", 1'b0, F_HU, 8'h10, 32'h0, 32'h0000BEEF, 1'b0);

        // 3: byte and halfword merges
        xact("sb11",  1'b1, F_B,  8'h11, 32'h123456AA, 32'h0,        1'b0);
        xact("lw10b", 1'b0, F_W,  8'h10, 32'h0,        32'hDEADAAEF, 1'b0);
        xact("sh12",  1'b1, F_H,  8'h12, 32'h00007F01, 32'h0,        1'b0);
        xact("lw10c", 1'b0, F_W,  8'h10, 32'h0,        32'h7F01AAEF, 1'b0);

        // 4: misaligned and illegal-funct3 requests
        xact("sh11err",  1'b1, F_H,    8'h11, 32'hFFFFFFFF, 32'h0, 1'b1);
        xact("lw12err",  1'b0, F_W,    8'h12, 32'h0,        32'h0, 1'b1);
        xact("ld011err", 1'b0, 3'b011, 8'h10, 32'h0,        32'h0, 1'b1);
        xact("sbu_err",  1'b1, F_BU,   8'h10, 32'h00000055, 32'h0, 1'b1);
        xact("lw10d",    1'b0, F_W,    8'h10, 32'h0,        32'h7F01AAEF, 1'b0);

        // 5a: backpressure holds the response and blocks new requests
        @(negedge clk);
        rsp_ready  = 1'b0;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = F_W;
        req_addr   = 8'h10;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp.rsp_valid", {31'h0, rsp_valid}, 32'h1);
            check("bp.rsp_rdata", rsp_rdata, 32'h7F01AAEF);
            check("bp.req_ready", {31'h0, req_ready}, 32'h0);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp.release_ready", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        #1;
        check("bp.drained", {31'h0, rsp_valid}, 32'h0);

        // 5b: four back-to-back loads, one response per cycle
        valid_run = 0;
        xact("b2b0", 1'b0, F_W,  8'h10, 32'h0, 32'h7F01AAEF, 1'b0);
        if (rsp_valid) valid_run++;
        xact("b2b1", 1'b0, F_BU, 8'h10, 32'h0, 32'h000000EF, 1'b0);
        if (rsp_valid) valid_run++;
        xact("b2b2", 1'b0, F_B,  8'h11, 32'h0, 32'hFFFFFFAA, 1'b0);
        if (rsp_valid) valid_run++;
        xact("b2b3", 1'b0, F_H,  8'h12, 32'h0, 32'h00007F01, 1'b0);
        if (rsp_valid) valid_run++;
        check("b2b.run", valid_run, 32'd4);
        @(posedge clk);
        #1;
        check("b2b.idle", {31'h0, rsp_valid}, 32'h0);

        // 6: reset with a pending response and a concurrent store
        @(negedge clk);
        rsp_ready  = 1'b0;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = F_W;
        req_addr   = 8'h10;
        @(posedge clk);
        #1;
        check("rst.pending", {31'h0, rsp_valid}, 32'h1);
        @(negedge clk);
        reset      = 1'b0;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = F_W;
        req_addr   = 8'h10;
        req_wdata  = 32'h0;
        @(posedge clk);
        #1;
        check("rst.rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst.req_ready", {31'h0, req_ready}, 32'h1);
        check("rst.rsp_rdata", rsp_rdata, 32'h0);
        @(negedge clk);
        reset     = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        xact("rst.lw10", 1'b0, F_W, 8'h10, 32'h0, 32'h7F01AAEF, 1'b0);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
